multi_cycle_ctrl: RTL and testbench

//  Main control FSM of the multi-cycle CPU; drives ALUop and the Func-select that the ALU control

---
 rtl/multi_cycle_ctrl_pkg.sv | 71 +++++++
 rtl/multi_cycle_ctrl_outdec.sv | 80 ++++++++
 rtl/multi_cycle_ctrl.sv | 107 ++++++++++
 tb/tb_multi_cycle_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU main controller:
// opcodes, ALU/mux encodings, state codes and the control-word payload.
package multi_cycle_ctrl_pkg;

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [1:0] ALUOP_ADD = 2'b11;
  localparam logic [1:0] ALUOP_SUB = 2'b10;
  localparam logic [1:0] ALUOP_R   = 2'b01;
  localparam logic [1:0] ALUOP_I   = 2'b00;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_I_EXEC    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_HALT      = 4'd12
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_func_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic logic is_itype(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_outdec.sv
// Pure combinational state-to-control-word decode; mem_ready only gates
// the FETCH-cycle IR/PC writes.
module mc_ctrl_outdec
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  state_e     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic go;
  assign go = mem_ready || (MEM_HANDSHAKE == 1'b0);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = go;
        ctrl.pc_write  = go;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_R;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALUOP_I;
        ctrl.alu_func_sel = 1'b1;
      end
      ST_I_WB: ctrl.reg_write = 1'b1;
      // PC update on zero is qualified by the datapath, not here
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: FETCH, DECODE, then a per-class
// sequence, stalling on mem_ready in the memory-access states.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  input  logic            zero,
  output logic [1:0]      ALUop,
  output logic            ALUFuncSel,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            illegal,
  output logic [ST_W-1:0] state_dbg
);

  state_e state, state_next;
  ctrl_t  dec, ctrl;
  logic   go, op_known;
  logic   unused_zero;

  // zero is ANDed with PCWriteCond in the datapath
  assign unused_zero = zero;
  assign go          = mem_ready || (MEM_HANDSHAKE == 1'b0);
  assign op_known    = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                       (opcode == OP_BEQ) || (opcode == OP_J) || is_itype(opcode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:     if (go) state_next = ST_DECODE;
      ST_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_next = ST_MEM_ADDR;
        else if (opcode == OP_RTYPE)                state_next = ST_R_EXEC;
        else if (opcode == OP_BEQ)                  state_next = ST_BRANCH;
        else if (opcode == OP_J)                    state_next = ST_JUMP;
        else if (is_itype(opcode))                  state_next = ST_I_EXEC;
        else state_next = ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
      end
      ST_MEM_ADDR:  state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (go) state_next = ST_MEM_WB;
      ST_MEM_WB:    state_next = ST_FETCH;
      ST_MEM_WRITE: if (go) state_next = ST_FETCH;
      ST_R_EXEC:    state_next = ST_R_WB;
      ST_R_WB:      state_next = ST_FETCH;
      ST_I_EXEC:    state_next = ST_I_WB;
      ST_I_WB:      state_next = ST_FETCH;
      ST_BRANCH:    state_next = ST_FETCH;
      ST_JUMP:      state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_FETCH;
    endcase
  end

  mc_ctrl_outdec #(.MEM_HANDSHAKE(MEM_HANDSHAKE)) u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Reset forces every control output low immediately, independent of the clock
  always_comb begin
    ctrl    = dec;
    illegal = (state == ST_DECODE) && !op_known;
    if (rst) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  assign ALUop       = ctrl.alu_op;
  assign ALUFuncSel  = ctrl.alu_func_sel;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign state_dbg   = ST_W'(state);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle expected state/control words are queued
// per instruction and popped against both a trapping and a non-trapping instance.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] aluop;
    logic       fsel;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw, pcwc, iord, mrd, mwr, irw, rw, rdst, m2r, ill;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       ill;
  } step_t;

  logic       clk = 1'b0;
  logic       rst, mem_ready, zero;
  logic [5:0] opcode;

  logic [1:0] ALUop, ALUSrcB, PCSource;
  logic       ALUFuncSel, ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, RegWrite, RegDst, MemtoReg, illegal;
  logic [3:0] state_dbg;

  logic [1:0] n_ALUop, n_ALUSrcB, n_PCSource;
  logic       n_ALUFuncSel, n_ALUSrcA, n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite;
  logic       n_IRWrite, n_RegWrite, n_RegDst, n_MemtoReg, n_illegal;
  logic [3:0] n_state_dbg;

  ctl_t  obs, n_obs;
  step_t sq[$];
  int    compared = 0;
  int    mismatched = 0;

  assign obs   = {ALUop, ALUFuncSel, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                  MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, illegal};
  assign n_obs = {n_ALUop, n_ALUFuncSel, n_ALUSrcA, n_ALUSrcB, n_PCSource, n_PCWrite, n_PCWriteCond,
                  n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_RegWrite, n_RegDst, n_MemtoReg, n_illegal};

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .ALUop(ALUop), .ALUFuncSel(ALUFuncSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal(illegal), .state_dbg(state_dbg)
  );

  multi_cycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .ALUop(n_ALUop), .ALUFuncSel(n_ALUFuncSel), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .PCSource(n_PCSource), .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD),
    .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .RegWrite(n_RegWrite),
    .RegDst(n_RegDst), .MemtoReg(n_MemtoReg), .illegal(n_illegal), .state_dbg(n_state_dbg)
  );

  // Expected control word per state, written out from the state table
  function automatic ctl_t exp_vec(input logic [3:0] st, input logic rdy, input logic ill);
    ctl_t e;
    e = '0;
    case (st)
      4'd0:  begin e.mrd = 1'b1; e.srcb = 2'b01; e.aluop = 2'b11; e.irw = rdy; e.pcw = rdy; end
      4'd1:  begin e.srcb = 2'b11; e.aluop = 2'b11; e.ill = ill; end
      4'd2:  begin e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 2'b11; end
      4'd3:  begin e.mrd = 1'b1; e.iord = 1'b1; end
      4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
      4'd5:  begin e.mwr = 1'b1; e.iord = 1'b1; end
      4'd6:  begin e.srca = 1'b1; e.srcb = 2'b00; e.aluop = 2'b01; end
      4'd7:  begin e.rw = 1'b1; e.rdst = 1'b1; end
      4'd8:  begin e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 2'b00; e.fsel = 1'b1; end
      4'd9:  e.rw = 1'b1;
      4'd10: begin e.srca = 1'b1; e.aluop = 2'b10; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
      4'd11: begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic ill);
    step_t s;
    s = '{st: st, rdy: rdy, ill: ill};
    sq.push_back(s);
  endtask

  // Expected per-cycle sequence for one instruction; fw/mw = ready-low cycles
  task automatic enqueue_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 1'b0);
    push(4'd0, 1'b1, 1'b0);
    push(4'd1, rnd(), 1'b0);
    case (op)
      6'b100011: begin
        push(4'd2, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) push(4'd3, 1'b0, 1'b0);
        push(4'd3, 1'b1, 1'b0);
        push(4'd4, rnd(), 1'b0);
      end
      6'b101011: begin
        push(4'd2, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) push(4'd5, 1'b0, 1'b0);
        push(4'd5, 1'b1, 1'b0);
      end
      6'b000000: begin push(4'd6, rnd(), 1'b0); push(4'd7, rnd(), 1'b0); end
      6'b000100: push(4'd10, rnd(), 1'b0);
      6'b000010: push(4'd11, rnd(), 1'b0);
      default:   begin push(4'd8, rnd(), 1'b0); push(4'd9, rnd(), 1'b0); end
    endcase
  endtask

  // Scoreboard consumer: called at a negedge, returns at a negedge
  task automatic drain(output int rw_cycles);
    step_t s;
    ctl_t  e;
    rw_cycles = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy;
      #1;
      e = exp_vec(s.st, s.rdy, s.ill);
      compared++;
      if (state_dbg !== s.st || obs !== e) begin
        mismatched++;
        $display("FAIL step t=%0t state got %0d want %0d ctl got %h want %h",
                 $time, state_dbg, s.st, obs, e);
      end
      if (RegWrite === 1'b1) rw_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int rw;
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (state_dbg !== 4'd0 || obs !== ctl_t'(0) || n_state_dbg !== 4'd0 || n_obs !== ctl_t'(0)) begin
      mismatched++;
      $display("FAIL reset state got %0d ctl got %h want 0/0", state_dbg, obs);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    push(4'd0, 1'b0, 1'b0);
    drain(rw);
  endtask

  task automatic test_r_type();
    int rw;
    opcode = OP_RTYPE;
    enqueue_instr(OP_RTYPE, 0, 0);
    drain(rw);
    compared++;
    if (rw !== 1) begin
      mismatched++;
      $display("FAIL r_type_regwrite_cycles got %0d want 1", rw);
    end
  endtask

  task automatic test_lw_stall();
    int rw;
    opcode = OP_LW;
    enqueue_instr(OP_LW, 0, 3);
    drain(rw);
    compared++;
    if (rw !== 1) begin
      mismatched++;
      $display("FAIL lw_regwrite_cycles got %0d want 1", rw);
    end
  endtask

  task automatic test_itype();
    int rw;
    logic [5:0] ops [5];
    ops = '{OP_ORI, OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI};
    foreach (ops[i]) begin
      opcode = ops[i];
      enqueue_instr(ops[i], int'($urandom_range(0, 2)), 0);
      drain(rw);
    end
  endtask

  task automatic test_branch();
    int rw;
    opcode = OP_BEQ;
    zero = 1'b1;
    enqueue_instr(OP_BEQ, 0, 0);
    drain(rw);
    zero = 1'b0;
    enqueue_instr(OP_BEQ, 1, 0);
    drain(rw);
  endtask

  task automatic test_back_to_back();
    int rw;
    logic [5:0] ops [7];
    ops = '{OP_SW, OP_J, OP_RTYPE, OP_LW, OP_BEQ, OP_SLTI, OP_SW};
    foreach (ops[i]) begin
      opcode = ops[i];
      enqueue_instr(ops[i], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      drain(rw);
    end
  endtask

  task automatic test_rst_mid_mem();
    int rw;
    opcode = OP_LW;
    push(4'd0, 1'b1, 1'b0);
    push(4'd1, 1'b1, 1'b0);
    push(4'd2, 1'b1, 1'b0);
    push(4'd3, 1'b0, 1'b0);
    drain(rw);
    compared++;
    if (state_dbg !== 4'd3) begin
      mismatched++;
      $display("FAIL pre_reset_state got %0d want 3", state_dbg);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (state_dbg !== 4'd0 || obs !== ctl_t'(0)) begin
      mismatched++;
      $display("FAIL async_reset state got %0d ctl got %h want 0/0", state_dbg, obs);
    end
    @(negedge clk);
    rst = 1'b0;
    push(4'd0, 1'b0, 1'b0);
    drain(rw);
    compared++;
    if (rw !== 0) begin
      mismatched++;
      $display("FAIL regwrite_after_reset got %0d want 0", rw);
    end
  endtask

  task automatic test_illegal();
    step_t s;
    ctl_t  e, ne;
    logic [3:0] nst;
    int k;
    opcode = 6'b111111;
    push(4'd0, 1'b1, 1'b0);
    push(4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) push(4'd12, 1'b0, 1'b0);
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy;
      #1;
      e   = exp_vec(s.st, s.rdy, s.ill);
      nst = (k == 1) ? 4'd1 : 4'd0;
      ne  = exp_vec(nst, s.rdy, s.ill);
      compared++;
      if (state_dbg !== s.st || obs !== e) begin
        mismatched++;
        $display("FAIL illegal_trap k=%0d state got %0d want %0d ctl got %h want %h",
                 k, state_dbg, s.st, obs, e);
      end
      compared++;
      if (n_state_dbg !== nst || n_obs !== ne) begin
        mismatched++;
        $display("FAIL illegal_notrap k=%0d state got %0d want %0d ctl got %h want %h",
                 k, n_state_dbg, nst, n_obs, ne);
      end
      k++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (state_dbg !== 4'd0 || obs !== ctl_t'(0)) begin
      mismatched++;
      $display("FAIL halt_exit_reset state got %0d ctl got %h want 0/0", state_dbg, obs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_stall();
    test_itype();
    test_branch();
    test_back_to_back();
    test_rst_mid_mem();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
